vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
- Produces the raster scan that feeds the pixel colour driver: `current_row`/`current_line` pixel coordinates, an active-video `enable`, and the VGA `hsync`/`vsync` pulses.
- Takes the driver's 12-bit `color_out` back in and drives the physical 12-bit RGB pins, blanked outside active video.
- Sits between the board clock and the VGA connector; the colour driver hangs off its coordinate outputs.
- Fixed mode: 640x480 @ 60 Hz, 25 MHz pixel rate derived from `clk_in` by an integer clock-enable divider.

Parameters:
- CLK_DIV, 4, `clk_in` cycles per pixel (100 MHz / 4 = 25 MHz); legal 1..16.
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BP, 48, horizontal back porch, in pixels.
- V_VISIBLE, 480, active lines per frame.
- V_FP, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BP, 33, vertical back porch, in lines.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- color_in  input  12  pixel colour from the colour driver, {R[3:0],G[3:0],B[3:0]}.
- current_row  output  10  horizontal counter, 0..799.
- current_line  output  10  vertical counter, 0..524.
- enable  output  1  high iff current_row < 640 and current_line < 480.
- pix_tick  output  1  one-`clk_in` strobe marking the pixel-clock enable.
- frame_start  output  1  one-`clk_in` pulse when counters wrap to (0,0).
- hsync  output  1  active-low horizontal sync.
- vsync  output  1  active-low vertical sync.
- vga_rgb  output  12  colour to the connector; 0 while blanked.

Behaviour:
- Reset values:
  - Asynchronous assert on `rst_n_in` low; release is synchronous to `clk_in`.
  - All counters, `current_row`, `current_line`, `enable`, `pix_tick`, `frame_start` and `vga_rgb` reset to 0.
  - `hsync` and `vsync` reset to 1 (inactive).
- Divider:
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_tick` = 1 in the cycle where `div_cnt` == CLK_DIV-1.
  - With CLK_DIV = 1, `pix_tick` is constant 1 after reset.
- Horizontal counter:
  - Advances only on `pix_tick`; H_TOTAL = 800.
  - At 799 it wraps to 0 and the vertical counter advances.
- Vertical counter:
  - V_TOTAL = 525; at 524, together with the horizontal wrap, it goes to 0.
  - `frame_start` is a single-cycle pulse in the `clk_in` cycle after the (799,524)->(0,0) transition.
- Registered outputs:
  - All outputs are registered and reflect counter state one `clk_in` cycle after the `pix_tick` that produced it.
  - Between ticks, outputs hold.
- Sync decode (combinational from counters, then registered):
  - `hsync` = 0 iff 656 <= h <= 751.
  - `vsync` = 0 iff 490 <= v <= 491.
- Blanking:
  - `enable` = (h < 640) && (v < 480).
  - `vga_rgb` = `color_in` when the aligned `enable` is 1, else 12'h000. It is registered every `clk_in` cycle, not only on ticks.
- Width rules:
  - Porch sums are computed as 10-bit constants.
  - Counter compares are unsigned; no output ever exceeds 799 / 524.
- Reset mid-frame: everything returns to (0,0) with syncs inactive; the first visible pixel follows after one full divider period.
- Interface contract with the colour driver:
  - The driver registers its colour on `clk_in`, so `color_in` lags coordinates by one cycle.
  - Correct alignment of sync and blanking to that lag is provided by the optional feature below.

Optional Feature:
- Macro: `VGA_SYNC_DELAY_EN`.
- Defined: `hsync`, `vsync` and the blanking `enable` used for `vga_rgb` gating pass through one extra `clk_in` register stage. This makes them coincide with the driver's registered colour. The `enable` port itself is not delayed.
  - Reset value of the delay stage: syncs 1, blank 0.
- Undefined: no delay stage; syncs and gating are aligned to the coordinates. Each line's first pixel then shows the previous cycle's colour.

Decomposition:
- Package `vga_timing_pkg`:
  - Localparams H_TOTAL = 800, V_TOTAL = 525.
  - Sync start/end constants: HS_START = 656, HS_END = 751, VS_START = 490, VS_END = 491.
  - `rgb12_t` typedef.
- One natural sub-module, `pixel_clk_divider`: the divider producing `pix_tick`. Counters, decode and output registers stay in the top.

Test Plan:
- Reset/divider: hold `rst_n_in`=0 for 10 cycles, release with CLK_DIV=4 -> `hsync`=`vsync`=1 and all other outputs 0 during reset; after release, `pix_tick` asserts every 4th `clk_in` cycle.
- Line timing: run one line -> `hsync` low for exactly 96 ticks starting at h=656; `enable` high for exactly 640 ticks; `current_row` wraps 799->0.
- Frame timing: run one full frame -> `vsync` low on lines 490-491 only; `frame_start` pulses exactly once every 420000 ticks (800x525); `current_line` wraps 524->0.
- Blanking: drive `color_in`=12'hF0F constantly -> `vga_rgb`=12'hF0F for h<640, v<480; 12'h000 at h=640 and at v=480.
- Reset mid-operation: assert `rst_n_in` at h=300, v=200 -> outputs go to reset values immediately, without waiting for a clock edge; counting restarts at (0,0) after release.
- Macro: compile with `VGA_SYNC_DELAY_EN` -> `hsync` falls one `clk_in` cycle later than without it, and `vga_rgb` is nonzero for the cycle after `enable` drops.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480@60 timing constants, colour type and window helper
//   H_TOTAL/V_TOTAL        : full line / frame length in pixels / lines
//   HS_*/VS_*              : inclusive sync pulse windows
//   rgb12_t                : {R[3:0],G[3:0],B[3:0]}
//   in_window()            : inclusive unsigned range test on a 10-bit counter
package vga_timing_pkg;

    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] V_TOTAL  = 10'd525;
    localparam logic [9:0] HS_START = 10'd656;
    localparam logic [9:0] HS_END   = 10'd751;
    localparam logic [9:0] VS_START = 10'd490;
    localparam logic [9:0] VS_END   = 10'd491;

    typedef logic [11:0] rgb12_t;

    function automatic logic in_window(input logic [9:0] val, input logic [9:0] lo, input logic [9:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_generator_pixel_clk_divider.sv
// pixel_clk_divider: integer clock-enable divider producing the pixel strobe
//   clk_in   : system clock
//   rst_n_in : asynchronous active-low reset
//   pix_tick : high for one clk_in cycle out of every CLK_DIV (constant 1 when CLK_DIV = 1)
module pixel_clk_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_in,
    input  logic rst_n_in,
    output logic pix_tick
);

    localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_cnt;
    logic [3:0] div_nxt;

    always_comb div_nxt = (div_cnt == LAST) ? 4'd0 : div_cnt + 4'd1;

    // The strobe is registered from the next count so it is high exactly
    // while div_cnt sits at CLK_DIV-1, yet still reads 0 during reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            div_cnt  <= '0;
            pix_tick <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            pix_tick <= (div_nxt == LAST);
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: 640x480@60 raster timing, sync generation and RGB blanking
//   clk_in       : system clock (CLK_DIV cycles per pixel)
//   rst_n_in     : asynchronous active-low reset, synchronous release
//   color_in     : pixel colour from the colour driver (registered there, lags coordinates by one cycle)
//   current_row  : horizontal pixel coordinate, 0..H_TOTAL-1
//   current_line : vertical line coordinate, 0..V_TOTAL-1
//   enable       : active-video flag aligned with the coordinates
//   pix_tick     : pixel-clock enable strobe
//   frame_start  : one-cycle pulse when the coordinates wrap to (0,0)
//   hsync/vsync  : active-low sync pulses
//   vga_rgb      : colour to the connector, 0 while blanked
// Build option VGA_SYNC_DELAY_EN: delays syncs and the rgb gating by one clk_in
// cycle so they line up with the colour driver's registered output.
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = int'(HS_START) - 640,
    parameter int H_SYNC    = int'(HS_END) - int'(HS_START) + 1,
    parameter int H_BP      = int'(H_TOTAL) - int'(HS_END) - 1,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = int'(VS_START) - 480,
    parameter int V_SYNC    = int'(VS_END) - int'(VS_START) + 1,
    parameter int V_BP      = int'(V_TOTAL) - int'(VS_END) - 1
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  rgb12_t       color_in,
    output logic [9:0]   current_row,
    output logic [9:0]   current_line,
    output logic         enable,
    output logic         pix_tick,
    output logic         frame_start,
    output logic         hsync,
    output logic         vsync,
    output rgb12_t       vga_rgb
);

    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] H_LAST = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_LO  = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_HI  = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] V_LAST = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_LO  = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_HI  = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_wrap;
    logic       en_cur;
    logic       hs_cur;
    logic       vs_cur;
    logic       fs_cur;
    logic       en_next;
    logic       gate;
    logic       hs_r;
    logic       vs_r;

    pixel_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .pix_tick (pix_tick)
    );

    // h_cnt/v_cnt point at the pixel that the next tick will publish; the
    // outputs are a tick-registered snapshot, so after reset the first tick
    // shows (0,0) and the first visible pixel is not skipped.
    always_comb begin
        h_wrap  = (h_cnt == H_LAST);
        h_nxt   = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt   = !h_wrap ? v_cnt : (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        en_cur  = (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs_cur  = !in_window(h_cnt, HS_LO, HS_HI);
        vs_cur  = !in_window(v_cnt, VS_LO, VS_HI);
        // A genuine wrap only: the published coordinates leave the last pixel,
        // which rules out the first (0,0) after reset.
        fs_cur  = (h_cnt == 10'd0) && (v_cnt == 10'd0) && (current_row == H_LAST) && (current_line == V_LAST);
        // Value enable will hold next cycle, so vga_rgb can switch with it.
        en_next = pix_tick ? en_cur : enable;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            h_cnt        <= '0;
            v_cnt        <= '0;
            current_row  <= '0;
            current_line <= '0;
            enable       <= 1'b0;
            frame_start  <= 1'b0;
            hs_r         <= 1'b1;
            vs_r         <= 1'b1;
            vga_rgb      <= '0;
        end else begin
            frame_start <= pix_tick && fs_cur;
            vga_rgb     <= gate ? color_in : 12'h000;
            if (pix_tick) begin
                h_cnt        <= h_nxt;
                v_cnt        <= v_nxt;
                current_row  <= h_cnt;
                current_line <= v_cnt;
                enable       <= en_cur;
                hs_r         <= hs_cur;
                vs_r         <= vs_cur;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_d;
    logic vs_d;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hs_d <= 1'b1;
            vs_d <= 1'b1;
        end else begin
            hs_d <= hs_r;
            vs_d <= vs_r;
        end
    end

    // Gating from the current enable makes vga_rgb trail the coordinates by
    // one cycle, matching the driver's registered colour.
    assign hsync = hs_d;
    assign vsync = vs_d;
    assign gate  = enable;
`else
    assign hsync = hs_r;
    assign vsync = vs_r;
    assign gate  = en_next;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: randomized-colour bench with an arithmetic raster reference model
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    localparam int CD  = 4;
    localparam int HT  = 800;
    localparam int HV  = 640;
    localparam int HS0 = 656;
    localparam int HS1 = 751;
    localparam int VV  = 4;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 1;
    localparam int VT  = VV + VFP + VSY + VBP;
    localparam int VS0 = VV + VFP;
    localparam int VS1 = VV + VFP + VSY - 1;

    logic       clk_in;
    logic       rst_n_in;
    rgb12_t     color_in;
    logic [9:0] current_row;
    logic [9:0] current_line;
    logic       enable;
    logic       pix_tick;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    rgb12_t     vga_rgb;

    int checks;
    int errors;
    int c;
    int fs_seen;
    rgb12_t prev_color;

    vga_timing_generator #(
        .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .color_in     (color_in),
        .current_row  (current_row),
        .current_line (current_line),
        .enable       (enable),
        .pix_tick     (pix_tick),
        .frame_start  (frame_start),
        .hsync        (hsync),
        .vsync        (vsync),
        .vga_rgb      (vga_rgb)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at c=%0d: got %0d expected %0d", tag, c, got, exp);
        end
    endtask

    // After c clock edges since release, c/CD pixel ticks have completed and
    // the outputs show pixel number (ticks-1) of the raster in scan order.
    function automatic int exp_row(input int cc);
        return (cc < CD) ? 0 : (cc / CD - 1) % HT;
    endfunction

    function automatic int exp_line(input int cc);
        return (cc < CD) ? 0 : ((cc / CD - 1) / HT) % VT;
    endfunction

    function automatic int exp_en(input int cc);
        return (cc >= CD && exp_row(cc) < HV && exp_line(cc) < VV) ? 1 : 0;
    endfunction

    function automatic int exp_hs(input int cc);
        return (cc >= CD && exp_row(cc) >= HS0 && exp_row(cc) <= HS1) ? 0 : 1;
    endfunction

    function automatic int exp_vs(input int cc);
        return (cc >= CD && exp_line(cc) >= VS0 && exp_line(cc) <= VS1) ? 0 : 1;
    endfunction

    function automatic int exp_fs(input int cc);
        return (cc % CD == 0 && cc / CD > 1 && (cc / CD - 1) % (HT * VT) == 0) ? 1 : 0;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_row"}, current_row, 0);
        check({tag, "_line"}, current_line, 0);
        check({tag, "_en"}, enable, 0);
        check({tag, "_tick"}, pix_tick, 0);
        check({tag, "_fs"}, frame_start, 0);
        check({tag, "_hs"}, hsync, 1);
        check({tag, "_vs"}, vsync, 1);
        check({tag, "_rgb"}, vga_rgb, 0);
    endtask

    task automatic drive_color();
        prev_color = rgb12_t'($urandom);
        color_in   = prev_color;
    endtask

    task automatic step();
        int g;
        @(posedge clk_in);
        c++;
        @(negedge clk_in);
        check("row", current_row, exp_row(c));
        check("line", current_line, exp_line(c));
        check("en", enable, exp_en(c));
        check("tick", pix_tick, (c % CD == CD - 1) ? 1 : 0);
        check("fs", frame_start, exp_fs(c));
`ifdef VGA_SYNC_DELAY_EN
        check("hs", hsync, exp_hs(c - 1));
        check("vs", vsync, exp_vs(c - 1));
        g = exp_en(c - 1);
`else
        check("hs", hsync, exp_hs(c));
        check("vs", vsync, exp_vs(c));
        g = exp_en(c);
`endif
        check("rgb", vga_rgb, (g != 0) ? int'(prev_color) : 0);
        if (frame_start) fs_seen++;
        drive_color();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        c        = 0;
        fs_seen  = 0;
        rst_n_in = 1'b0;
        drive_color();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_in);
            check_reset("por");
            drive_color();
        end
        rst_n_in = 1'b1;
        c = 0;
        while (c < 2 * HT + 300 + 1) begin
            if (c == (2 * HT + 300 + 1) * CD) break;
            step();
            if (c == (2 * HT + 300 + 1) * CD) break;
        end
        while (c < (2 * HT + 300 + 1) * CD) step();
        check("mid_row", current_row, 300);
        check("mid_line", current_line, 2);
        #2 rst_n_in = 1'b0;
        #1 check_reset("async");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            check_reset("hold");
            drive_color();
        end
        rst_n_in = 1'b1;
        c = 0;
        fs_seen = 0;
        while (c < 2 * HT * VT * CD + 10) step();
        check("fs_count", fs_seen, 2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
